// File: rtl/ahb_subordinate_ram.sv
// ----------------------------------------------------------------------------
// ahb_subordinate_ram
// AHB subordinate backed by a DEPTH x DATA_WDT RAM with byte-lane writes,
// optional wait states (i_stall) and two-cycle ERROR/RETRY responses.
//
// Ports:
//   i_hclk, i_hreset_n        clock (rising edge), async active-low reset
//   i_hsel, i_haddr, i_htrans,
//   i_hburst, i_hwrite,
//   i_hsize, i_hwdata,
//   i_hready                  AHB request side (i_hburst is not checked)
//   o_hrdata, o_hreadyout,
//   o_hresp                   AHB response side
//   i_stall                   holds a valid data phase in wait while high
//   i_retry                   answers the next accepted transfer with RETRY
// ----------------------------------------------------------------------------
package ahb_subordinate_ram_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01,
        HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11
    } t_htrans;
    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0, HBURST_INCR = 3'd1, HBURST_WRAP4 = 3'd2,
        HBURST_INCR4 = 3'd3, HBURST_WRAP8 = 3'd4, HBURST_INCR8 = 3'd5,
        HBURST_WRAP16 = 3'd6, HBURST_INCR16 = 3'd7
    } t_hburst;
    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2,
        HSIZE_DWORD = 3'd3, HSIZE_4WORD = 3'd4, HSIZE_8WORD = 3'd5,
        HSIZE_16WORD = 3'd6, HSIZE_32WORD = 3'd7
    } t_hsize;
    typedef enum logic [1:0] {
        HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10, HRESP_SPLIT = 2'b11
    } t_hresp;
endpackage

module ahb_subordinate_ram
    import ahb_subordinate_ram_pkg::*;
#(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 256
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  t_htrans             i_htrans,
    input  t_hburst             i_hburst,
    input  logic                i_hwrite,
    input  t_hsize              i_hsize,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hreadyout,
    output t_hresp              o_hresp,
    input  logic                i_stall,
    input  logic                i_retry
);

    localparam int NB = DATA_WDT / 8;
    localparam int LG = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_OKAY_PH = 3'd0, ST_WAIT = 3'd1, ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3, ST_RTY1 = 3'd4, ST_RTY2 = 3'd5
    } t_state;

    logic [DATA_WDT-1:0] r_mem [DEPTH];
    t_state              r_state;
    t_state              w_next_state;
    t_state              w_new_state;
    logic                r_act;
    logic                w_next_act;
    logic                w_new_act;
    logic                r_write;
    logic [AW-1:0]       r_idx;
    logic [NB-1:0]       r_be;
    logic                w_dp;
    logic                w_hready;
    t_hresp              w_hresp;
    logic                w_start;
    logic                w_size_bad;
    logic                w_align_bad;
    logic                w_range_bad;
    logic                w_wr_en;
    logic                w_unused;

    // Byte lanes covered by an access of 2**size bytes at lane offset off.
    function automatic logic [NB-1:0] f_lane_mask(input logic [LG-1:0] off,
                                                  input logic [2:0]    size);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            if ((b >= int'(off)) && (b < int'(off) + (1 << int'(size)))) begin
                m[b] = 1'b1;
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    // Burst type is accepted but has no effect on this subordinate.
    assign w_unused = ^i_hburst;

    // A valid transfer owns the data phase in OKAY_PH (when active) or WAIT.
    assign w_dp = ((r_state == ST_OKAY_PH) && r_act) || (r_state == ST_WAIT);

    // Response decode: ready low on first error/retry cycle or while stalled.
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        case (r_state)
            ST_OKAY_PH: begin
                if (r_act && i_stall) w_hready = 1'b0;
                else                  w_hready = 1'b1;
            end
            ST_WAIT:  w_hready = ~i_stall;
            ST_ERR1:  begin w_hready = 1'b0; w_hresp = HRESP_ERROR; end
            ST_ERR2:  begin w_hready = 1'b1; w_hresp = HRESP_ERROR; end
            ST_RTY1:  begin w_hready = 1'b0; w_hresp = HRESP_RETRY; end
            ST_RTY2:  begin w_hready = 1'b1; w_hresp = HRESP_RETRY; end
            default:  begin w_hready = 1'b1; w_hresp = HRESP_OKAY; end
        endcase
    end

    // Own ready gates acceptance so address phases during wait cycles are ignored.
    assign w_start = i_hsel & i_hready & w_hready &
                     ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));
    assign w_size_bad  = int'(i_hsize) > LG;
    assign w_range_bad = (i_haddr >> (LG + AW)) != 32'd0;

    // Misalignment: any address bit below the access size set.
    always_comb begin
        w_align_bad = 1'b0;
        for (int b = 0; b < LG; b++) begin
            if ((b < int'(i_hsize)) && i_haddr[b]) w_align_bad = 1'b1;
            else                                    w_align_bad = w_align_bad;
        end
    end

    // Classify the address phase seen in a cycle where this subordinate is ready.
    always_comb begin
        w_new_state = ST_OKAY_PH;
        w_new_act   = 1'b0;
        if (w_start) begin
            if (w_size_bad || w_align_bad || w_range_bad) begin
                w_new_state = ST_ERR1;
            end else if (i_retry) begin
                w_new_state = ST_RTY1;
            end else begin
                w_new_state = ST_OKAY_PH;
                w_new_act   = 1'b1;
            end
        end else begin
            w_new_state = ST_OKAY_PH;
            w_new_act   = 1'b0;
        end
    end

    // Next-state logic and write strobe for the completing data phase.
    always_comb begin
        w_next_state = r_state;
        w_next_act   = r_act;
        w_wr_en      = 1'b0;
        case (r_state)
            ST_OKAY_PH, ST_WAIT: begin
                if (w_dp && i_stall) begin
                    w_next_state = ST_WAIT;
                    w_next_act   = 1'b1;
                end else begin
                    w_wr_en      = w_dp & r_write;
                    w_next_state = w_new_state;
                    w_next_act   = w_new_act;
                end
            end
            ST_ERR1: begin w_next_state = ST_ERR2; w_next_act = 1'b0; end
            ST_RTY1: begin w_next_state = ST_RTY2; w_next_act = 1'b0; end
            ST_ERR2, ST_RTY2: begin
                w_next_state = w_new_state;
                w_next_act   = w_new_act;
            end
            default: begin w_next_state = ST_OKAY_PH; w_next_act = 1'b0; end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_state <= ST_OKAY_PH;
            r_act   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_act   <= w_next_act;
        end
    end

    // Capture of the accepted transfer's direction, word index and lanes.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_write <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
        end else if (w_start) begin
            r_write <= i_hwrite;
            r_idx   <= i_haddr[LG +: AW];
            r_be    <= f_lane_mask(i_haddr[LG-1:0], i_hsize);
        end else begin
            r_write <= r_write;
            r_idx   <= r_idx;
            r_be    <= r_be;
        end
    end

    // RAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge i_hclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (r_be[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

    // Read data: asynchronous array read, so a write committed at the edge
    // ending the previous data phase is already visible (forwarding).
    always_comb begin
        if (w_dp && !r_write) o_hrdata = r_mem[r_idx];
        else                  o_hrdata = '0;
    end

    assign o_hreadyout = w_hready;
    assign o_hresp     = w_hresp;

endmodule

// File: tb/tb_ahb_subordinate_ram.sv
// ----------------------------------------------------------------------------
// tb_ahb_subordinate_ram
// Directed self-checking bench for ahb_subordinate_ram (DATA_WDT=32,
// DEPTH=256). Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ahb_subordinate_ram;
    import ahb_subordinate_ram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    t_htrans     htrans;
    t_hburst     hburst;
    logic        hwrite;
    t_hsize      hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    t_hresp      hresp;
    logic        stall;
    logic        retry;

    int n_chk;
    int n_pass;

    ahb_subordinate_ram #(.DATA_WDT(32), .DEPTH(256)) dut (
        .i_hclk      (clk),
        .i_hreset_n  (rst_n),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hburst    (hburst),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready),
        .o_hrdata    (hrdata),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .i_stall     (stall),
        .i_retry     (retry)
    );

    // Single subordinate on the bus: bus HREADY is its own HREADYOUT.
    assign hready = hreadyout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_phase(input string tag, input logic rdy,
                               input t_hresp rsp, input logic [31:0] dat);
        check_val({tag, ".hreadyout"}, {63'd0, hreadyout}, {63'd0, rdy});
        check_val({tag, ".hresp"}, {62'd0, hresp}, {62'd0, rsp});
        check_val({tag, ".hrdata"}, {32'd0, hrdata}, {32'd0, dat});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_ap(input logic wr, input logic [31:0] addr,
                          input t_hsize sz, input logic rty);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        retry  = rty;
    endtask

    task automatic set_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hsize  = HSIZE_WORD;
        retry  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input t_hsize sz,
                            input logic [31:0] data);
        set_ap(1'b1, addr, sz, 1'b0);
        tick();
        set_idle();
        hwdata = data;
        mid();
        check_phase("wr_dp", 1'b1, HRESP_OKAY, 32'd0);
        tick();
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp);
        set_ap(1'b0, addr, HSIZE_WORD, 1'b0);
        tick();
        set_idle();
        mid();
        check_phase(tag, 1'b1, HRESP_OKAY, exp);
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        hburst = HBURST_SINGLE;
        hwdata = 32'd0;
        stall  = 1'b0;
        set_idle();

        // Reset values
        #2;
        check_phase("reset", 1'b1, HRESP_OKAY, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        mid();
        check_phase("idle", 1'b1, HRESP_OKAY, 32'd0);
        tick();

        // Word write then zero-wait read
        do_write(32'h10, HSIZE_WORD, 32'hDEADBEEF);
        do_read("rd_word", 32'h10, 32'hDEADBEEF);

        // Byte write to lane 3, then stalled read (3 wait cycles)
        do_write(32'h13, HSIZE_BYTE, 32'hAA000000);
        set_ap(1'b0, 32'h10, HSIZE_WORD, 1'b0);
        tick();
        set_idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check_val("stall.hreadyout", {63'd0, hreadyout}, 64'd0);
            check_val("stall.hresp", {62'd0, hresp}, {62'd0, HRESP_OKAY});
            tick();
        end
        stall = 1'b0;
        mid();
        check_phase("rd_stall", 1'b1, HRESP_OKAY, 32'hAAADBEEF);
        tick();

        // Back-to-back write then read of the same word (forwarding)
        set_ap(1'b1, 32'h20, HSIZE_WORD, 1'b0);
        tick();
        set_ap(1'b0, 32'h20, HSIZE_WORD, 1'b0);
        hwdata = 32'h12345678;
        mid();
        check_phase("fwd_wr", 1'b1, HRESP_OKAY, 32'd0);
        tick();
        set_idle();
        mid();
        check_phase("fwd_rd", 1'b1, HRESP_OKAY, 32'h12345678);
        tick();

        // Misaligned word write; address phase during ERR1 must be ignored
        do_write(32'h00, HSIZE_WORD, 32'h01020304);
        set_ap(1'b1, 32'h02, HSIZE_WORD, 1'b0);
        tick();
        set_ap(1'b1, 32'h00, HSIZE_WORD, 1'b0);
        hwdata = 32'hFFFFFFFF;
        mid();
        check_phase("err_al1", 1'b0, HRESP_ERROR, 32'd0);
        tick();
        set_idle();
        mid();
        check_phase("err_al2", 1'b1, HRESP_ERROR, 32'd0);
        tick();
        mid();
        check_phase("err_after", 1'b1, HRESP_OKAY, 32'd0);
        tick();
        do_read("err_al_rb", 32'h00, 32'h01020304);

        // Word index == DEPTH; read pipelined in ERR2 is accepted
        set_ap(1'b1, 32'h400, HSIZE_WORD, 1'b0);
        tick();
        set_idle();
        hwdata = 32'hFFFFFFFF;
        mid();
        check_phase("err_rg1", 1'b0, HRESP_ERROR, 32'd0);
        tick();
        set_ap(1'b0, 32'h00, HSIZE_WORD, 1'b0);
        mid();
        check_phase("err_rg2", 1'b1, HRESP_ERROR, 32'd0);
        tick();
        set_idle();
        mid();
        check_phase("err_rg_rb", 1'b1, HRESP_OKAY, 32'h01020304);
        tick();

        // Oversized access
        set_ap(1'b0, 32'h00, HSIZE_DWORD, 1'b0);
        tick();
        set_idle();
        mid();
        check_phase("err_sz1", 1'b0, HRESP_ERROR, 32'd0);
        tick();
        mid();
        check_phase("err_sz2", 1'b1, HRESP_ERROR, 32'd0);
        tick();

        // Retry: two-cycle RETRY, RAM untouched, then a clean reissue
        do_write(32'h40, HSIZE_WORD, 32'h0BADF00D);
        set_ap(1'b1, 32'h40, HSIZE_WORD, 1'b1);
        tick();
        set_idle();
        hwdata = 32'h00000055;
        mid();
        check_phase("rty1", 1'b0, HRESP_RETRY, 32'd0);
        tick();
        mid();
        check_phase("rty2", 1'b1, HRESP_RETRY, 32'd0);
        tick();
        do_read("rty_rb", 32'h40, 32'h0BADF00D);
        do_write(32'h40, HSIZE_WORD, 32'h00000055);
        do_read("rty_reissue", 32'h40, 32'h00000055);

        // Reset in the middle of a stalled write
        do_write(32'h50, HSIZE_WORD, 32'hCAFEF00D);
        set_ap(1'b1, 32'h50, HSIZE_WORD, 1'b0);
        tick();
        set_idle();
        hwdata = 32'h11111111;
        stall  = 1'b1;
        mid();
        check_val("rst_wait.hreadyout", {63'd0, hreadyout}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_phase("rst_async", 1'b1, HRESP_OKAY, 32'd0);
        tick();
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        do_read("rst_rb", 32'h50, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
